// File: rtl/dmem_mmio.sv
// dmem_mmio: data-memory responder for the single-cycle core.
// Word RAM at the bottom of the address space plus a 32-byte peripheral
// page (LED, synchronized switches, timer/compare, byte TX FIFO).
// Reads are combinational; every state change lands on the rising edge.
module dmem_mmio #(
   parameter int unsigned RAM_WORDS  = 64,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] MMIO_BASE  = 32'h0000_0800
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   input  logic [15:0] sw_in,
   output logic [15:0] led_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int unsigned      RAM_AW    = $clog2(RAM_WORDS);
   localparam int unsigned      FIFO_AW   = $clog2(FIFO_DEPTH);
   localparam logic [31:0]      RAM_BYTES = 32'(RAM_WORDS * 4);
   localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(FIFO_DEPTH);

   localparam logic [2:0] OFF_LED    = 3'd0;
   localparam logic [2:0] OFF_SW     = 3'd1;
   localparam logic [2:0] OFF_TIMER  = 3'd2;
   localparam logic [2:0] OFF_CMP    = 3'd3;
   localparam logic [2:0] OFF_STATUS = 3'd4;
   localparam logic [2:0] OFF_TX     = 3'd5;

   // storage
   logic [31:0]        ram_mem [RAM_WORDS];
   logic [7:0]         fifo_q  [FIFO_DEPTH];
   logic [7:0]         fifo_d  [FIFO_DEPTH];

   // registered state
   logic [15:0]        led_q, led_d;
   logic [15:0]        sync1_q, sync1_d;
   logic [15:0]        sync2_q, sync2_d;
   logic [31:0]        timer_q, timer_d;
   logic [31:0]        cmp_q, cmp_d;
   logic               match_q, match_d;
   logic               ovf_q, ovf_d;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;

   // decode / handshake
   logic               ram_sel, mmio_hit;
   logic [2:0]         off;
   logic [RAM_AW-1:0]  ram_idx;
   logic               ram_we, mmio_we;
   logic               push, pop, push_ok;
   logic               fifo_full, fifo_empty;
   logic [31:0]        status;

   // Address decode; RAM wins if the peripheral page were placed inside it.
   always_comb begin
      ram_sel    = ALUResult < RAM_BYTES;
      mmio_hit   = !ram_sel && (ALUResult[31:5] == MMIO_BASE[31:5]);
      off        = ALUResult[4:2];
      ram_idx    = ALUResult[RAM_AW+1:2];
      ram_we     = MemWrite && !reset && ram_sel;
      mmio_we    = MemWrite && mmio_hit;
      fifo_empty = count_q == '0;
      fifo_full  = count_q == DEPTH_C;
      tx_valid   = !fifo_empty;
      tx_data    = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
      led_out    = led_q;
      push       = mmio_we && (off == OFF_TX);
      pop        = tx_valid && tx_ready;
      // A pop frees a slot in the same edge, so a full FIFO still takes the byte.
      push_ok    = push && (!fifo_full || pop);
      status     = {24'h0, 4'(count_q), ovf_q, fifo_empty, fifo_full, match_q};
   end

   // Combinational read mux; reads never change state.
   always_comb begin
      ReadData = 32'h0;
      if (ram_sel) begin
         ReadData = ram_mem[ram_idx];
      end else if (mmio_hit) begin
         case (off)
            OFF_LED:    ReadData = {16'h0, led_q};
            OFF_SW:     ReadData = {16'h0, sync2_q};
            OFF_TIMER:  ReadData = timer_q;
            OFF_CMP:    ReadData = cmp_q;
            OFF_STATUS: ReadData = status;
            default:    ReadData = 32'h0;
         endcase
      end
   end

   // Next-state for peripherals and FIFO; sticky sets override W1C clears.
   always_comb begin
      led_d    = led_q;
      sync1_d  = sw_in;
      sync2_d  = sync1_q;
      timer_d  = timer_q + 32'd1;
      cmp_d    = cmp_q;
      match_d  = match_q;
      ovf_d    = ovf_q;
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (mmio_we) begin
         case (off)
            OFF_LED:    led_d = WriteData[15:0];
            OFF_TIMER:  timer_d = WriteData;
            OFF_CMP:    cmp_d = WriteData;
            OFF_STATUS: begin
               if (WriteData[0]) match_d = 1'b0;
               if (WriteData[3]) ovf_d = 1'b0;
            end
            default: ;
         endcase
      end
      if (timer_q == cmp_q) match_d = 1'b1;
      if (push && !push_ok) ovf_d = 1'b1;
      if (push_ok) begin
         fifo_d[wr_ptr_q] = WriteData[7:0];
         wr_ptr_d         = wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
         2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Peripheral state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         led_q    <= '0;
         sync1_q  <= '0;
         sync2_q  <= '0;
         timer_q  <= '0;
         cmp_q    <= '0;
         match_q  <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         led_q    <= led_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         timer_q  <= timer_d;
         cmp_q    <= cmp_d;
         match_q  <= match_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO payload needs no reset; emptiness comes from count_q.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (ram_we) ram_mem[ram_idx] <= WriteData;
   end

endmodule
